// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Sequencing controller for a multi-cycle RV32 subset datapath. Every
// instruction goes through FETCH, DECODE and EXECUTE. Depending on its class
// it then goes through MEMORY and/or WRITEBACK. One memory port is shared by
// instruction fetch and data access through a req/ready handshake. Retired
// instructions are counted in instret_o.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-low reset
//   start_i       level-sensitive run enable
//   op_i          opcode field of the instruction register
//   zero_i        ALU zero flag (branch condition)
//   mem_ready_i   memory completes the current access this cycle
//   mem_req_o     memory access request
//   mem_we_o      write strobe, qualified by mem_req_o
//   iord_o        address select: 0 = PC, 1 = ALU result register
//   ir_write_o    load IR and old-PC register
//   pc_write_o    load PC
//   pc_src_o      PC source: 0 = ALU (pc+4), 1 = branch target
//   alu_src_a_o   0 = PC, 1 = rs1
//   alu_src_b_o   00 = rs2, 01 = constant 4, 10 = immediate
//   alu_op_o      00 = add, 01 = sub/compare, 10 = decode funct
//   reg_write_o   register file write enable
//   mem_to_reg_o  writeback source: 0 = ALU, 1 = memory data register
//   state_o       current state encoding
//   err_o         illegal opcode trap
//   instret_o     retired instruction count (wraps)
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [6:0]           op_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 iord_o,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic                 pc_src_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [1:0]           alu_op_o,
  output logic                 reg_write_o,
  output logic                 mem_to_reg_o,
  output logic [3:0]           state_o,
  output logic                 err_o,
  output logic [INSTRET_W-1:0] instret_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WR = 4'd7,
    S_WB_ALU = 4'd8,
    S_WB_MEM = 4'd9,
    S_BRANCH = 4'd10,
    S_ERR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_retire;
  logic [INSTRET_W-1:0]   r_instret;

  // State register; reset returns to IDLE, which drives every output low.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Retired-instruction counter, bumped on the edge leaving a retiring state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_instret <= {INSTRET_W{1'b0}};
    end else if (w_retire) begin
      r_instret <= r_instret + {{(INSTRET_W-1){1'b0}}, 1'b1};
    end else begin
      r_instret <= r_instret;
    end
  end

  // Next-state and output decode; Mealy terms use mem_ready_i and zero_i.
  always_comb begin
    w_next       = r_state;
    w_retire     = 1'b0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    iord_o       = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    err_o        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start_i) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_IDLE;
        end
      end

      S_FETCH: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          w_next     = S_DECODE;
        end else begin
          w_next     = S_FETCH;
        end
      end

      S_DECODE: begin
        case (op_i)
          OP_R:      w_next = S_EXEC_R;
          OP_I:      w_next = S_EXEC_I;
          OP_LOAD:   w_next = S_ADDR;
          OP_STORE:  w_next = S_ADDR;
          OP_BRANCH: w_next = S_BRANCH;
          default:   w_next = S_ERR;
        endcase
      end

      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
        w_next      = S_WB_ALU;
      end

      S_EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        alu_op_o    = 2'b10;
        w_next      = S_WB_ALU;
      end

      S_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        // IR is not rewritten after FETCH, so op_i still holds the
        // load/store opcode here. Bit 5 separates store from load.
        if (op_i[5]) begin
          w_next = S_MEM_WR;
        end else begin
          w_next = S_MEM_RD;
        end
      end

      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        if (mem_ready_i) begin
          w_next = S_WB_MEM;
        end else begin
          w_next = S_MEM_RD;
        end
      end

      S_MEM_WR: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_ready_i) begin
          w_retire = 1'b1;
          w_next   = start_i ? S_FETCH : S_IDLE;
        end else begin
          w_next   = S_MEM_WR;
        end
      end

      S_WB_ALU: begin
        reg_write_o = 1'b1;
        w_retire    = 1'b1;
        w_next      = start_i ? S_FETCH : S_IDLE;
      end

      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
        w_retire     = 1'b1;
        w_next       = start_i ? S_FETCH : S_IDLE;
      end

      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i;
        w_retire    = 1'b1;
        w_next      = start_i ? S_FETCH : S_IDLE;
      end

      S_ERR: begin
        err_o  = 1'b1;
        w_next = S_ERR;
      end

      // Unused encodings are treated as a fault and trapped.
      default: begin
        w_next = S_ERR;
      end
    endcase
  end

  assign state_o   = r_state;
  assign instret_o = r_instret;

endmodule
